mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester byte-serial RAM arbiter: instruction fetches and data loads/stores share one byte-wide port.
// Define MEM_ARBITER_PERF_EN to add the wait/stall performance counter outputs.
module mem_arbiter #(
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        _inst_req,
    input  logic [31:0] _inst_addr,
    output logic        _inst_done,
    output logic [31:0] _inst_data,
    input  logic        _data_req,
    input  logic        _data_wr,
    input  logic [31:0] _data_addr,
    input  logic [31:0] _data_wdata,
    input  logic [1:0]  _data_size,
    output logic        _data_done,
    output logic [31:0] _data_rdata
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0] _perf_inst_wait,
    output logic [31:0] _perf_data_wait,
    output logic [31:0] _perf_io_stall
`endif
);

    localparam int STREAK_W = (DATA_STREAK_MAX < 1) ? 1 : $clog2(DATA_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(DATA_STREAK_MAX);
    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    state_t              state;
    state_t              state_next;
    owner_t              owner;
    logic [31:0]         addr_r;
    logic [31:0]         wdata_r;
    logic                wr_r;
    logic [1:0]          last_idx;
    logic [1:0]          idx;
    logic [1:0]          idx_inc;
    logic [31:0]         rbuf;
    logic [31:0]         rbuf_next;
    logic [7:0]          dout_r;
    logic                wr_out_r;
    logic                inst_done_r;
    logic                data_done_r;
    logic [31:0]         inst_data_r;
    logic [31:0]         data_rdata_r;
    logic [STREAK_W-1:0] streak;

    logic data_io_blocked;
    logic data_eligible;
    logic data_wins;
    logic grant_inst;
    logic grant_data;
    logic last_byte;
    logic abort;

    // Size code 2 is illegal and is handled as a full word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            2'd0:    last_index = 2'd0;
            2'd1:    last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    assign data_io_blocked = io_buffer_full && (_data_addr >= IO_BASE);
    assign data_eligible   = _data_req && !data_io_blocked;
    assign idx_inc         = idx + 2'd1;

    always_comb begin
        rbuf_next = rbuf;
        rbuf_next[{idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_next = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        data_wins  = 1'b0;
        abort      = 1'b0;
        last_byte  = (idx == last_idx);
        case (state)
            IDLE: begin
                data_wins = data_eligible && !(_inst_req && (streak == STREAK_TOP));
                if (!_clear) begin
                    if (data_wins) begin
                        grant_data = 1'b1;
                        state_next = XFER;
                    end else if (_inst_req) begin
                        grant_inst = 1'b1;
                        state_next = XFER;
                    end
                end
            end
            XFER: begin
                // A flush kills fetches and loads, but a store already on the bus is committed.
                if (_clear && !((owner == OWN_DATA) && wr_r)) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (last_byte) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            owner        <= OWN_NONE;
            addr_r       <= 32'h0;
            wdata_r      <= 32'h0;
            wr_r         <= 1'b0;
            last_idx     <= 2'd0;
            idx          <= 2'd0;
            rbuf         <= 32'h0;
            dout_r       <= 8'h00;
            wr_out_r     <= 1'b0;
            inst_done_r  <= 1'b0;
            data_done_r  <= 1'b0;
            inst_data_r  <= 32'h0;
            data_rdata_r <= 32'h0;
        end else if (rdy_in) begin
            inst_done_r <= 1'b0;
            data_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        owner    <= OWN_DATA;
                        idx      <= 2'd0;
                        rbuf     <= 32'h0;
                        addr_r   <= _data_addr;
                        wdata_r  <= _data_wdata;
                        wr_r     <= _data_wr;
                        last_idx <= last_index(_data_size);
                        wr_out_r <= _data_wr;
                        dout_r   <= _data_wr ? _data_wdata[7:0] : 8'h00;
                    end else if (grant_inst) begin
                        owner    <= OWN_INST;
                        idx      <= 2'd0;
                        rbuf     <= 32'h0;
                        addr_r   <= _inst_addr;
                        wdata_r  <= 32'h0;
                        wr_r     <= 1'b0;
                        last_idx <= 2'd3;
                        wr_out_r <= 1'b0;
                        dout_r   <= 8'h00;
                    end
                end
                XFER: begin
                    if (abort) begin
                        owner    <= OWN_NONE;
                        wr_out_r <= 1'b0;
                        dout_r   <= 8'h00;
                    end else if (last_byte) begin
                        wr_out_r <= 1'b0;
                        dout_r   <= 8'h00;
                        if (owner == OWN_INST) begin
                            inst_done_r <= 1'b1;
                            inst_data_r <= rbuf_next;
                        end else begin
                            data_done_r <= 1'b1;
                            if (!wr_r) begin
                                data_rdata_r <= rbuf_next;
                            end
                        end
                    end else begin
                        idx    <= idx_inc;
                        addr_r <= addr_r + 32'd1;
                        rbuf   <= rbuf_next;
                        if (wr_r) begin
                            dout_r <= wdata_r[{idx_inc, 3'b000} +: 8];
                        end
                    end
                end
                DONE:    owner <= OWN_NONE;
                default: owner <= OWN_NONE;
            endcase
        end
    end

    // Counts data grants won while a fetch is kept waiting; hitting the cap hands the next slot to the fetch.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            streak <= '0;
        end else if (rdy_in) begin
            if (!_inst_req || (_clear && (state != XFER))) begin
                streak <= '0;
            end else if (grant_data) begin
                streak <= (streak == STREAK_TOP) ? streak : streak + STREAK_W'(1);
            end else if (grant_inst) begin
                streak <= '0;
            end
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            _perf_inst_wait <= 32'h0;
            _perf_data_wait <= 32'h0;
            _perf_io_stall  <= 32'h0;
        end else if (rdy_in) begin
            if (_inst_req && !((state == XFER) && (owner == OWN_INST))) begin
                _perf_inst_wait <= _perf_inst_wait + 32'd1;
            end
            if (_data_req && !((state == XFER) && (owner == OWN_DATA))) begin
                _perf_data_wait <= _perf_data_wait + 32'd1;
            end
            if (_data_req && data_io_blocked) begin
                _perf_io_stall <= _perf_io_stall + 32'd1;
            end
        end
    end
`endif

    // A flush seen during the done cycle cancels the pulse, except for a store that has already committed.
    assign _inst_done  = inst_done_r && !_clear;
    assign _data_done  = data_done_r && !(_clear && !wr_r);
    assign _inst_data  = inst_data_r;
    assign _data_rdata = data_rdata_r;
    assign mem_a       = addr_r;
    assign mem_dout    = dout_r;
    assign mem_wr      = wr_out_r && rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, priority streak, IO stall, flush, freeze and reset scenarios.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_done;
    logic [31:0] inst_data;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [1:0]  data_size;
    logic        data_done;
    logic [31:0] data_rdata;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_inst_wait;
    logic [31:0] perf_data_wait;
    logic [31:0] perf_io_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [39:0] write_log[$];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_STREAK_MAX(4)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .rdy_in         (rdy),
        ._clear         (clear),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full),
        ._inst_req      (inst_req),
        ._inst_addr     (inst_addr),
        ._inst_done     (inst_done),
        ._inst_data     (inst_data),
        ._data_req      (data_req),
        ._data_wr       (data_wr),
        ._data_addr     (data_addr),
        ._data_wdata    (data_wdata),
        ._data_size     (data_size),
        ._data_done     (data_done),
        ._data_rdata    (data_rdata)
`ifdef MEM_ARBITER_PERF_EN
        ,
        ._perf_inst_wait(perf_inst_wait),
        ._perf_data_wait(perf_data_wait),
        ._perf_io_stall (perf_io_stall)
`endif
    );

    // Read-only RAM contents seen on mem_din within the same cycle as mem_a.
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h100: rom_byte = 8'h11;
            32'h101: rom_byte = 8'h22;
            32'h102: rom_byte = 8'h33;
            32'h103: rom_byte = 8'h44;
            32'h300: rom_byte = 8'h5A;
            32'h301: rom_byte = 8'h6B;
            32'h500: rom_byte = 8'hA1;
            32'h501: rom_byte = 8'hB2;
            32'h502: rom_byte = 8'hC3;
            32'h503: rom_byte = 8'hD4;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    always_comb mem_din = rom_byte(mem_a);

    always @(posedge clk) begin
        if (mem_wr) write_log.push_back({mem_a, mem_dout});
    end

    function automatic logic [39:0] log_entry(input int k);
        if (k < write_log.size()) log_entry = write_log[k];
        else log_entry = 40'hFF_FFFF_FFFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] ds);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_addr  = da;
        data_wdata = dwd;
        data_size  = ds;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of negedges until _data_done, or -1 on timeout; drops the data request on completion.
    task automatic waitDataDone(input int max_cycles, output int taken);
        taken = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            tick(1);
            if (data_done) begin
                taken = c;
                data_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic checkWrite(input string tag, input int k, input logic [31:0] addr, input logic [7:0] b);
        logic [39:0] e;
        e = log_entry(k);
        checkOutput({tag, "_addr"}, e[39:8], addr);
        checkOutput({tag, "_byte"}, {24'h0, e[7:0]}, {24'h0, b});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string order;
        string expected_order;
        int    base;
        int    taken;
        int    data_count;
        int    inst_at;
        int    data_at;

        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_full = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(2);
        checkOutput("rst_mem_a", mem_a, 0);
        checkOutput("rst_mem_wr", mem_wr, 0);
        checkOutput("rst_mem_dout", mem_dout, 0);
        checkOutput("rst_inst_done", inst_done, 0);
        checkOutput("rst_data_done", data_done, 0);
        checkOutput("rst_inst_data", inst_data, 0);
        checkOutput("rst_data_rdata", data_rdata, 0);
        rst = 1'b0;
        tick(1);

        $display("[TB] instruction fetch at 0x100");
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("fetch_addr%0d", i), mem_a, 32'h100 + i);
            checkOutput($sformatf("fetch_early_done%0d", i), inst_done, 0);
        end
        tick(1);
        checkOutput("fetch_done", inst_done, 1);
        checkOutput("fetch_data", inst_data, 32'h4433_2211);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(1);
        checkOutput("fetch_done_one_cycle", inst_done, 0);
        checkOutput("fetch_addr_hold", mem_a, 32'h103);

        $display("[TB] halfword store at 0x200");
        base = write_log.size();
        applyStimulus(0, 0, 1, 1, 32'h200, 32'hAABB_CCDD, 2'd1);
        tick(1);
        checkOutput("st_wr0", mem_wr, 1);
        checkOutput("st_dout0", mem_dout, 32'hDD);
        checkOutput("st_addr0", mem_a, 32'h200);
        tick(1);
        checkOutput("st_wr1", mem_wr, 1);
        checkOutput("st_dout1", mem_dout, 32'hCC);
        checkOutput("st_addr1", mem_a, 32'h201);
        tick(1);
        checkOutput("st_done", data_done, 1);
        checkOutput("st_wr_off", mem_wr, 0);
        checkOutput("st_dout_off", mem_dout, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick(1);
        checkOutput("st_done_one_cycle", data_done, 0);
        checkOutput("st_write_count", write_log.size() - base, 2);
        checkWrite("st_w0", base, 32'h200, 8'hDD);
        checkWrite("st_w1", base + 1, 32'h201, 8'hCC);

        $display("[TB] data streak against waiting fetch");
        order = "";
        expected_order = "DDDDIDD";
        data_count = 0;
        applyStimulus(1, 32'h100, 1, 0, 32'h300, 0, 2'd0);
        for (int c = 0; c < 300 && order.len() < 7; c++) begin
            tick(1);
            if (data_done) begin
                order = {order, "D"};
                data_count++;
                if (data_count == 1) checkOutput("load_zero_fill", data_rdata, 32'h0000_005A);
                if (data_count == 6) data_req = 1'b0;
            end
            if (inst_done) order = {order, "I"};
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("grant_count", order.len(), 7);
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("grant_order%0d", k),
                        (k < order.len()) ? {24'h0, order[k]} : 32'h0, {24'h0, expected_order[k]});
        end
        tick(2);

        $display("[TB] store to IO region while buffer full");
        base = write_log.size();
        inst_at = -1;
        data_at = -1;
        io_full = 1'b1;
        applyStimulus(1, 32'h100, 1, 1, 32'h0003_0000, 32'h0000_0077, 2'd0);
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (inst_done && inst_at < 0) inst_at = c;
            if (data_done && data_at < 0) data_at = c;
            if (c == 5) begin
                io_full  = 1'b0;
                inst_req = 1'b0;
            end
            if (data_done) data_req = 1'b0;
        end
        checkOutput("io_inst_done_cycle", inst_at, 5);
        checkOutput("io_store_done_cycle", data_at, 8);
        checkOutput("io_write_count", write_log.size() - base, 1);
        checkWrite("io_w0", base, 32'h0003_0000, 8'h77);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] flush during fetch");
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        tick(3);
        checkOutput("flush_at_byte2", mem_a, 32'h102);
        clear = 1'b1;
        inst_req = 1'b0;
        tick(1);
        checkOutput("flush_no_done", inst_done, 0);
        checkOutput("flush_addr_hold", mem_a, 32'h102);
        clear = 1'b0;
        applyStimulus(0, 0, 1, 0, 32'h300, 0, 2'd0);
        tick(1);
        checkOutput("flush_idle_next", mem_a, 32'h300);
        checkOutput("flush_no_late_done", inst_done, 0);
        waitDataDone(10, taken);
        checkOutput("flush_load_cycles", taken, 1);
        checkOutput("flush_load_data", data_rdata, 32'h0000_005A);
        tick(1);

        $display("[TB] flush during word store");
        base = write_log.size();
        applyStimulus(0, 0, 1, 1, 32'h400, 32'h1122_3344, 2'd3);
        tick(1);
        checkOutput("cst_addr0", mem_a, 32'h400);
        tick(1);
        checkOutput("cst_addr1", mem_a, 32'h401);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        checkOutput("cst_continues_wr", mem_wr, 1);
        checkOutput("cst_continues_addr", mem_a, 32'h402);
        waitDataDone(10, taken);
        checkOutput("cst_done_cycles", taken, 2);
        checkOutput("cst_write_count", write_log.size() - base, 4);
        checkWrite("cst_w0", base, 32'h400, 8'h44);
        checkWrite("cst_w1", base + 1, 32'h401, 8'h33);
        checkWrite("cst_w2", base + 2, 32'h402, 8'h22);
        checkWrite("cst_w3", base + 3, 32'h403, 8'h11);
        tick(1);

        $display("[TB] freeze during word load");
        applyStimulus(0, 0, 1, 0, 32'h500, 0, 2'd3);
        tick(2);
        checkOutput("frz_addr1", mem_a, 32'h501);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checkOutput($sformatf("frz_addr_hold%0d", k), mem_a, 32'h501);
            checkOutput($sformatf("frz_wr%0d", k), mem_wr, 0);
            checkOutput($sformatf("frz_no_done%0d", k), data_done, 0);
        end
        rdy = 1'b1;
        waitDataDone(12, taken);
        checkOutput("frz_done_cycles", taken, 3);
        checkOutput("frz_data", data_rdata, 32'hD4C3_B2A1);
        tick(1);

        $display("[TB] freeze and reset during word store");
        base = write_log.size();
        applyStimulus(0, 0, 1, 1, 32'h600, 32'hCAFE_F00D, 2'd3);
        tick(1);
        checkOutput("rs_wr_on", mem_wr, 1);
        checkOutput("rs_dout0", mem_dout, 32'h0D);
        rdy = 1'b0;
        tick(1);
        checkOutput("rs_wr_gated", mem_wr, 0);
        checkOutput("rs_addr_hold", mem_a, 32'h600);
        rdy = 1'b1;
        tick(1);
        checkOutput("rs_addr1", mem_a, 32'h601);
        checkOutput("rs_dout1", mem_dout, 32'hF0);
        rst = 1'b1;
        rdy = 1'b0;
        clear = 1'b1;
        tick(1);
        checkOutput("rs_mem_a", mem_a, 0);
        checkOutput("rs_mem_dout", mem_dout, 0);
        checkOutput("rs_mem_wr", mem_wr, 0);
        checkOutput("rs_data_done", data_done, 0);
        checkOutput("rs_inst_data", inst_data, 0);
        checkOutput("rs_data_rdata", data_rdata, 0);
        rst = 1'b0;
        rdy = 1'b1;
        clear = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rs_write_count", write_log.size() - base, 1);
        checkWrite("rs_w0", base, 32'h600, 8'h0D);
        tick(1);

        $display("[TB] flush with simultaneous request, illegal size");
        clear = 1'b1;
        applyStimulus(0, 0, 1, 0, 32'h500, 0, 2'd2);
        tick(1);
        checkOutput("clr_no_grant", mem_a, 0);
        clear = 1'b0;
        tick(1);
        checkOutput("clr_grant_after", mem_a, 32'h500);
        waitDataDone(10, taken);
        checkOutput("size2_cycles", taken, 4);
        checkOutput("size2_word", data_rdata, 32'hD4C3_B2A1);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
